// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types and constants for the add_share_arb block
package add_arb_pkg;
  localparam int DATA_W = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
endpackage

// File: rtl/add_share_arb_rr_pick.sv
// rr_pick: round-robin pick of the first valid index after last
// ports: valid request vector; last previous grant; gnt chosen index; any some request valid
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  gnt,
  output logic            any
);
  // scan farthest-first so the nearest valid index after last wins
  always_comb begin
    gnt = '0;
    for (int k = NREQ; k >= 1; k--)
      if (valid[(int'(last) + k) % NREQ]) gnt = IDW'((int'(last) + k) % NREQ);
  end
  assign any = |valid;
endmodule

// File: rtl/cla32_ov.sv
// cla32_ov: 32-bit carry-lookahead adder with carry-out and carry into bit 31
// ports: a, b operands; ci carry-in; s sum; co carry out of bit 31; c31 carry into bit 31
module cla32_ov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co,
  output logic        c31
);
  logic [31:0] g, p;
  logic [32:0] c;
  logic gg, pg;
  assign g = a & b;
  assign p = a ^ b;
  // 4-bit groups: inner carries ripple, group carry-out is looked ahead
  always_comb begin
    c = '0;
    gg = 1'b0;
    pg = 1'b0;
    c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1]) | (&p[4*k+3 -: 3] & g[4*k]);
      pg = &p[4*k+3 -: 4];
      for (int j = 0; j < 3; j++) c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      c[4*k+4] = gg | (pg & c[4*k]);
    end
  end
  assign s   = p ^ c[31:0];
  assign co  = c[32];
  assign c31 = c[31];
endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin sequencer sharing one cla32_ov adder among NREQ requesters
// ports: clk, reset_n (async active-low); req_valid/req_ready/req_a/req_b/req_sub per requester;
//        rsp_valid/rsp_ready handshake with rsp_id, rsp_s, rsp_co, rsp_ov results;
//        ov_count saturating overflow-response counter only when ADD_ARB_STATS_EN is defined
module add_share_arb
  import add_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_s,
  output logic                   rsp_co,
  output logic                   rsp_ov
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [15:0]            ov_count
`endif
);
  state_e state_q, state_d;
  logic [IDW-1:0] last_q, gid_q, gnt;
  logic [DATA_W-1:0] op_a_q, op_b_q, s, b_sel;
  logic op_ci_q, co, c31, any, accept, rsp_hs;
  logic rsp_valid_q, rsp_co_q, rsp_ov_q;
  logic [IDW-1:0] rsp_id_q;
  logic [DATA_W-1:0] rsp_s_q;
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (.valid(req_valid), .last(last_q), .gnt(gnt), .any(any));
  cla32_ov u_add (.a(op_a_q), .b(op_b_q), .ci(op_ci_q), .s(s), .co(co), .c31(c31));
  assign accept    = (state_q == IDLE) && any;
  assign rsp_hs    = (state_q == RESP) && rsp_ready;
  assign req_ready = accept ? NREQ'(1) << gnt : '0;
  assign b_sel     = req_b[gnt*DATA_W +: DATA_W];
  always_comb begin
    state_d = accept ? CALC : (state_q == CALC) ? RESP : rsp_hs ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // subtract is A + ~B + 1, so the adder only ever adds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= IDW'(NREQ - 1);
      gid_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_ci_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_co_q    <= 1'b0;
      rsp_ov_q    <= 1'b0;
    end else begin
      if (accept) begin
        last_q  <= gnt;
        gid_q   <= gnt;
        op_a_q  <= req_a[gnt*DATA_W +: DATA_W];
        op_b_q  <= (req_sub[gnt] == OP_SUB) ? ~b_sel : b_sel;
        op_ci_q <= req_sub[gnt];
      end
      if (state_q == CALC) begin
        rsp_s_q     <= s;
        rsp_co_q    <= co;
        rsp_ov_q    <= co ^ c31;
        rsp_id_q    <= gid_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_ov    = rsp_ov_q;
`ifdef ADD_ARB_STATS_EN
  logic [15:0] ov_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ov_cnt_q <= '0;
    else if (rsp_hs && rsp_ov_q && ov_cnt_q != 16'hFFFF) ov_cnt_q <= ov_cnt_q + 16'd1;
  end
  assign ov_count = ov_cnt_q;
`endif
endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: vector table, corner sequences and randomized model check of add_share_arb
module tb_add_share_arb;
  localparam int NREQ = 3;
  localparam int IDW  = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [NREQ-1:0] req_valid, req_ready, req_sub;
  logic [NREQ*32-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_co, rsp_ov;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_s;
`ifdef ADD_ARB_STATS_EN
  logic [15:0] ov_count;
`endif
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int id;
    logic [31:0] a, b;
    logic sub;
    logic [31:0] s;
    logic co, ov;
  } vec_t;
  typedef struct {
    int id;
    logic [33:0] r;
  } exp_t;
  vec_t tbl[7];
  always #5 clk = ~clk;
  add_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co), .rsp_ov(rsp_ov)
`ifdef ADD_ARB_STATS_EN
    , .ov_count(ov_count)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference result {ov, co, s} from unsigned/signed arithmetic
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sa, sb, r;
    logic [32:0] u;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      co = a >= b;
      r = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b};
      co = u[32];
      r = sa + sb;
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ov, co, u[31:0]};
  endfunction
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction
  task automatic rst_dut();
    reset_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_valid[id] = 1'b1;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_sub[id] = sub;
  endtask
  task automatic wait_grant(input int id);
    int cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (req_ready[id]) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (cyc == 20) chk("grant_timeout", 32'(req_ready[id]), 1);
    else chk("grant_onehot", 32'(req_ready), 32'(1) << id);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    rsp_ready = 1'b1;
    drive(v.id, v.a, v.b, v.sub);
    wait_grant(v.id);
    @(negedge clk) chk("lat_calc_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("vec_valid", 32'(rsp_valid), 1);
    chk("vec_s", rsp_s, v.s);
    chk("vec_co", 32'(rsp_co), 32'(v.co));
    chk("vec_ov", 32'(rsp_ov), 32'(v.ov));
    chk("vec_id", 32'(rsp_id), v.id);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] corners[4];
    int n, last, gcyc, g;
    bit busy;
    logic [NREQ-1:0] drop;
    exp_t q[$];
    exp_t e;
    corners[0] = 32'h0; corners[1] = 32'h7FFFFFFF; corners[2] = 32'h80000000; corners[3] = 32'hFFFFFFFF;
    tbl[0] = '{0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[1] = '{1, 32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2] = '{1, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[3] = '{2, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[4] = '{0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
    tbl[5] = '{2, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[6] = '{0, 32'h7, 32'h3, 1'b1, 32'h4, 1'b1, 1'b0};
    req_a = '0; req_b = '0; req_sub = '0; req_valid = '0; rsp_ready = 1'b1;
    reset_n = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_co", 32'(rsp_co), 0);
    chk("rst_rsp_ov", 32'(rsp_ov), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    // two requesters held valid: grants must alternate starting at 0
    req_valid = 3'b011;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr_grant", 32'(req_ready), 32'(1) << (n % 2));
        n++;
      end
      @(posedge clk);
      #1;
    end
    chk("rr_count", n, 4);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    foreach (tbl[i]) run_vec(tbl[i]);
    // backpressure on the response channel
    rsp_ready = 1'b0;
    drive(2, 32'd1, 32'd2, 1'b0);
    wait_grant(2);
    @(negedge clk);
    @(negedge clk) chk("bp_valid", 32'(rsp_valid), 1);
    @(posedge clk);
    #1 drive(0, 32'd10, 32'd20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_s", rsp_s, 3);
      chk("bp_hold_id", 32'(rsp_id), 2);
      chk("bp_ready_low", 32'(req_ready), 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk) chk("bp_last_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("bp_released", 32'(rsp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk) chk("bp2_calc", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("bp2_valid", 32'(rsp_valid), 1);
    chk("bp2_s", rsp_s, 30);
    chk("bp2_id", 32'(rsp_id), 0);
    @(posedge clk);
    #1;
    // reset during CALC: transaction dropped, priority back to requester 0
    drive(0, 32'd1, 32'd1, 1'b0);
    wait_grant(0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1 req_valid = 3'b011;
    @(negedge clk) chk("mid_rst_grant0", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    // reset while a response is being presented clears it at once
    drive(1, 32'd4, 32'd4, 1'b0);
    wait_grant(1);
    @(negedge clk);
    @(negedge clk) chk("resp_rst_pre", 32'(rsp_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(rsp_valid), 0);
    chk("resp_rst_s", rsp_s, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
`ifdef ADD_ARB_STATS_EN
    rst_dut();
    run_vec(tbl[0]);
    run_vec(tbl[1]);
    run_vec(tbl[2]);
    run_vec(tbl[3]);
    run_vec(tbl[5]);
    chk("ov_count", 32'(ov_count), 3);
`endif
    // randomized traffic against the reference model
    rst_dut();
    last = NREQ - 1;
    busy = 1'b0;
    gcyc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      drop = '0;
      if (busy) chk("rnd_ready_busy", 32'(req_ready), 0);
      else if (|req_valid) begin
        g = pick(req_valid, last);
        chk("rnd_grant", 32'(req_ready), 32'(1) << g);
        e.id = g;
        e.r = model(req_a[g*32 +: 32], req_b[g*32 +: 32], req_sub[g]);
        q.push_back(e);
        last = g;
        busy = 1'b1;
        gcyc = cyc;
        drop[g] = 1'b1;
      end else chk("rnd_ready_idle", 32'(req_ready), 0);
      if (busy && cyc == gcyc + 2) chk("rnd_latency", 32'(rsp_valid), 1);
      if (rsp_valid) begin
        if (q.size() == 0) chk("rnd_spurious_rsp", 32'(rsp_valid), 0);
        else begin
          chk("rnd_id", 32'(rsp_id), q[0].id);
          chk("rnd_s", rsp_s, q[0].r[31:0]);
          chk("rnd_co", 32'(rsp_co), 32'(q[0].r[32]));
          chk("rnd_ov", 32'(rsp_ov), 32'(q[0].r[33]));
          if (rsp_ready) begin
            void'(q.pop_front());
            busy = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~drop;
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && !drop[i] && $urandom_range(0, 1) == 1)
          drive(i, $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 3)] : $urandom(),
                $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 3)] : $urandom(),
                1'($urandom_range(0, 1)));
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
